// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller.
// State encoding and counter sizing helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter needs $clog2(WIDTH) bits, but never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_simple.sv
// 1-bit full adder cell shared across the codebase; purely combinational.
module simple (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic cout,
    output logic sum
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: latches operands on start, feeds them
// LSB-first through one full adder cell, and pulses done with the final result.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             fa_sum;
    logic             fa_cout;

    simple u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .cout (fa_cout),
        .sum  (fa_sum)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = last ? ST_DONE : ST_RUN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // Shift-based fill avoids an empty slice when WIDTH is 1.
    always_comb begin
        res_nx = (res_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            cout_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= op_sub ? ~b_in : b_in;
                        carry <= op_sub ? 1'b1 : cin_in;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    carry  <= fa_cout;
                    res_sh <= res_nx;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        sum_out  <= res_nx;
                        cout_out <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, with a queue of
// expected results pushed at request time and popped when done pulses.
module tb_serial_add_ctrl;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       start8, sub8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       start1, sub1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_sub(sub8),
        .a_in(a8), .b_in(b8), .cin_in(cin8),
        .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op_sub(sub1),
        .a_in(a1), .b_in(b1), .cin_in(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // inject_at > 0 pulses start with other operands during RUN after that many edges.
    task automatic do_op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input int inject_at,
                         input string tag);
        exp_t       e;
        logic [8:0] r;
        int         lat;
        bit         seen;
        int         w;
        w = w1 ? 1 : 8;
        if (w1) begin
            r      = {8'b0, a[0]} + {8'b0, b[0]} + {8'b0, cin};
            e.sum  = {7'b0, r[0]};
            e.cout = r[1];
        end else begin
            if (sub) r = {1'b0, a} + {1'b0, ~b} + 9'd1;
            else     r = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            e.sum  = r[7:0];
            e.cout = r[8];
        end
        exp_q.push_back(e);

        @(negedge clk);
        if (w1) begin a1 = a[0]; b1 = b[0]; cin1 = cin; sub1 = sub; start1 = 1'b1; end
        else    begin a8 = a;    b8 = b;    cin8 = cin; sub8 = sub; start8 = 1'b1; end
        @(posedge clk); #1;
        check({tag, "_busy_e0"}, {31'b0, w1 ? busy1 : busy8}, 32'd1);
        check({tag, "_done_e0"}, {31'b0, w1 ? done1 : done8}, 32'd0);
        @(negedge clk);
        start1 = 1'b0; start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);

        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (w1 ? done1 : done8) begin
                seen = 1'b1;
                lat  = k;
            end else if (inject_at > 0 && k == inject_at) begin
                @(negedge clk);
                a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; sub8 = ~sub; start8 = 1'b1;
            end else if (inject_at > 0 && k == inject_at + 1) begin
                @(negedge clk);
                start8 = 1'b0;
            end
        end

        if (!seen) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            check({tag, "_latency"}, lat, w);
            if (w1) begin
                check({tag, "_sum"},  {31'b0, sum1}, {24'b0, e.sum});
                check({tag, "_cout"}, {31'b0, cout1}, {31'b0, e.cout});
            end else begin
                check({tag, "_sum"},  {24'b0, sum8}, {24'b0, e.sum});
                check({tag, "_cout"}, {31'b0, cout8}, {31'b0, e.cout});
            end
            start8 = 1'b0;
            for (int k = 0; k < 2; k++) begin
                @(posedge clk); #1;
                check({tag, "_done_after"}, {31'b0, w1 ? done1 : done8}, 32'd0);
                check({tag, "_busy_after"}, {31'b0, w1 ? busy1 : busy8}, 32'd0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; a1 = '0; b1 = '0;
        #2;
        check("rst_busy8", {31'b0, busy8}, 32'd0);
        check("rst_done8", {31'b0, done8}, 32'd0);
        check("rst_sum8",  {24'b0, sum8},  32'd0);
        check("rst_cout8", {31'b0, cout8}, 32'd0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op(1'b0, 8'h3C, 8'h0F, 1'b0, 1'b0, 0, "add_3c_0f");
        do_op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 0, "add_ff_01");
        do_op(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 0, "add_ff_01_c");
        do_op(1'b0, 8'h05, 8'h07, 1'b1, 1'b1, 0, "sub_05_07");
        do_op(1'b0, 8'h07, 8'h05, 1'b0, 1'b1, 0, "sub_07_05");
        do_op(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 3, "busy_start");

        // Abort mid-RUN: outputs must clear at once, not wait for an edge.
        @(negedge clk);
        a8 = 8'h99; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy8}, 32'd0);
        check("midrst_done", {31'b0, done8}, 32'd0);
        check("midrst_sum",  {24'b0, sum8},  32'd0);
        check("midrst_cout", {31'b0, cout8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op(1'b0, 8'hA5, 8'h5A, 1'b1, 1'b0, 0, "post_rst");

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            do_op(1'b1, {7'b0, v[2]}, {7'b0, v[1]}, v[0], 1'b0, 0, $sformatf("w1_fa%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
